apb_regfile_slave: RTL and testbench

//  Parametrised APB3 slave: bank of NUM_REGS word-wide RW registers at BASE_ADDR.

---
 rtl/apb_regfile_slave.sv | 126 ++++++++++++
 tb/tb_apb_regfile_slave.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// APB3 slave exposing NUM_REGS read/write words at BASE_ADDR, with wait states and PSLVERR.
// Optional byte-strobe writes are enabled by defining APB_PSTRB_EN.
module apb_regfile_slave #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          NUM_REGS    = 8,
    parameter int unsigned BASE_ADDR   = 'hA000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic [DATA_W-1:0]            pwdata,
    input  logic [DATA_W/8-1:0]          pstrb,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [IDX_W-1:0]  idx_q;
    logic              err_q;
    logic [3:0]        cnt;

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] off;
    logic              hit;
    logic [IDX_W-1:0]  idx_d;
    logic              setup;
    logic              access;
    logic              done;
    logic              orphan;
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;

    assign base   = ADDR_W'(BASE_ADDR);
    assign off    = paddr - base;
    assign hit    = (paddr >= base)
                 && (off < ADDR_W'(NUM_REGS * 4))
                 && (paddr[1:0] == 2'b00);
    assign idx_d  = off[IDX_W+1:2];

    assign setup  = psel & ~penable;
    assign access = psel & penable;
    assign done   = (state == ACCESS) && access && (cnt == 4'd0);
    // An access phase with no preceding setup is answered immediately as an error.
    assign orphan = (state == IDLE) && access;

    assign pready  = ~preset & (done | orphan);
    assign pslverr = ~preset & (orphan | (done & err_q));
    assign prdata  = (~preset & done & ~pwrite & ~err_q) ? regs[idx_q] : '0;

`ifdef APB_PSTRB_EN
    always_comb begin
        wmask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            wmask[b*8 +: 8] = {8{pstrb[b]}};
        end
    end
`else
    logic unused_strb;
    assign unused_strb = ^pstrb;
    assign wmask       = '1;
`endif

    assign wdata = (regs[idx_q] & ~wmask) | (pwdata & wmask);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
            idx_q <= '0;
            err_q <= 1'b0;
            cnt   <= 4'd0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (setup) begin
                        idx_q <= idx_d;
                        err_q <= ~hit;
                        cnt   <= 4'(WAIT_STATES);
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state <= IDLE;
                    end else if (!penable) begin
                        // A fresh setup replaces the pending transfer.
                        idx_q <= idx_d;
                        err_q <= ~hit;
                        cnt   <= 4'(WAIT_STATES);
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (pwrite && !err_q) begin
                            regs[idx_q] <= wdata;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_o[k*DATA_W +: DATA_W] = regs[k];
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed self-checking bench for apb_regfile_slave.
// Instance a uses WAIT_STATES=2, instance b uses WAIT_STATES=0.
module tb_apb_regfile_slave;

    logic         clk = 1'b0;
    logic         preset;
    logic         psel, penable, pwrite;
    logic [31:0]  paddr, pwdata;
    logic [3:0]   pstrb;
    int           tgt;

    logic [31:0]  prdata_a, prdata_b, prdata_t;
    logic         pready_a, pready_b, pready_t;
    logic         pslverr_a, pslverr_b, pslverr_t;
    logic [255:0] regs_a, regs_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_regfile_slave #(.WAIT_STATES(2)) u_dut_a (
        .pclk(clk), .preset(preset),
        .psel(psel & (tgt == 0)), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
        .regs_o(regs_a)
    );

    apb_regfile_slave #(.WAIT_STATES(0)) u_dut_b (
        .pclk(clk), .preset(preset),
        .psel(psel & (tgt == 1)), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b),
        .regs_o(regs_b)
    );

    assign prdata_t  = (tgt == 1) ? prdata_b  : prdata_a;
    assign pready_t  = (tgt == 1) ? pready_b  : pready_a;
    assign pslverr_t = (tgt == 1) ? pslverr_b : pslverr_a;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rdata,
                        output logic err, output int cycles);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(negedge clk);
        penable = 1'b1;
        cycles = 0;
        rdata = '0;
        err = 1'b0;
        forever begin
            #1;
            cycles++;
            if (pready_t) begin
                rdata = prdata_t;
                err = pslverr_t;
                break;
            end
            if (cycles > 20) break;
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    logic [31:0]  rd;
    logic         er;
    int           cy;
    logic [255:0] exp_regs;

    initial begin
        tgt = 0;
        preset = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (2) @(negedge clk);
        preset = 1'b0;
        #1;
        chk("rst_pready", 256'(pready_a), 256'(0));
        chk("rst_pslverr", 256'(pslverr_a), 256'(0));
        chk("rst_prdata", 256'(prdata_a), 256'(0));
        chk("rst_regs", regs_a, 256'(0));

        xfer(1'b0, 32'hA004, 32'h0, 4'hF, rd, er, cy);
        chk("rd0_cycles", 256'(cy), 256'(3));
        chk("rd0_data", 256'(rd), 256'(0));
        chk("rd0_err", 256'(er), 256'(0));
        idle();
        #1;
        chk("idle_pready", 256'(pready_a), 256'(0));

        xfer(1'b1, 32'hA00C, 32'hDEADBEEF, 4'hF, rd, er, cy);
        chk("wr3_cycles", 256'(cy), 256'(3));
        chk("wr3_err", 256'(er), 256'(0));
        chk("wr3_prdata", 256'(rd), 256'(0));
        idle();
        #1;
        exp_regs = 256'(32'hDEADBEEF) << 96;
        chk("wr3_regs", regs_a, exp_regs);
        xfer(1'b0, 32'hA00C, 32'h0, 4'hF, rd, er, cy);
        chk("rd3_data", 256'(rd), 256'(32'hDEADBEEF));
        chk("rd3_err", 256'(er), 256'(0));

        xfer(1'b1, 32'hA020, 32'h12345678, 4'hF, rd, er, cy);
        chk("oor_err", 256'(er), 256'(1));
        chk("oor_cycles", 256'(cy), 256'(3));
        xfer(1'b0, 32'hA002, 32'h0, 4'hF, rd, er, cy);
        chk("mis_err", 256'(er), 256'(1));
        chk("mis_prdata", 256'(rd), 256'(0));
        xfer(1'b0, 32'h9FFC, 32'h0, 4'hF, rd, er, cy);
        chk("below_err", 256'(er), 256'(1));
        xfer(1'b0, 32'hA01C, 32'h0, 4'hF, rd, er, cy);
        chk("top_err", 256'(er), 256'(0));
        idle();
        #1;
        chk("err_regs", regs_a, exp_regs);

        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'hA000; pwdata = 32'h1;
        @(negedge clk);
        penable = 1'b1;
        #1;
        chk("abort_wait", 256'(pready_a), 256'(0));
        idle();
        #1;
        chk("abort_pready", 256'(pready_a), 256'(0));
        idle();
        #1;
        chk("abort_regs", regs_a, exp_regs);

        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'hA00C;
        #1;
        chk("orphan_pready", 256'(pready_a), 256'(1));
        chk("orphan_err", 256'(pslverr_a), 256'(1));
        chk("orphan_prdata", 256'(prdata_a), 256'(0));
        idle();

        xfer(1'b1, 32'hA004, 32'h11223344, 4'hF, rd, er, cy);
        xfer(1'b1, 32'hA004, 32'hAABBCCDD, 4'b0101, rd, er, cy);
        chk("strb_err", 256'(er), 256'(0));
        idle();
        #1;
`ifdef APB_PSTRB_EN
        exp_regs[63:32] = 32'h11BB33DD;
`else
        exp_regs[63:32] = 32'hAABBCCDD;
`endif
        chk("strb_regs", regs_a, exp_regs);

        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'hA008; pwdata = 32'h55;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        preset = 1'b1;
        @(negedge clk);
        preset = 1'b0;
        psel = 1'b0; penable = 1'b0;
        #1;
        chk("rstmid_pready", 256'(pready_a), 256'(0));
        chk("rstmid_regs", regs_a, 256'(0));

        tgt = 1;
        xfer(1'b1, 32'hA01C, 32'hCAFEF00D, 4'hF, rd, er, cy);
        chk("ws0_wr_cycles", 256'(cy), 256'(1));
        chk("ws0_wr_err", 256'(er), 256'(0));
        xfer(1'b0, 32'hA01C, 32'h0, 4'hF, rd, er, cy);
        chk("ws0_rd_cycles", 256'(cy), 256'(1));
        chk("ws0_rd_data", 256'(rd), 256'(32'hCAFEF00D));
        idle();
        #1;
        chk("ws0_regs", regs_b, 256'(32'hCAFEF00D) << 224);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
